// File: rtl/vga_scan_timing_if.sv
// Scan-timing bundle between the VGA timing generator and the video-memory reader / DAC side.
interface vga_scan_timing_if;
  logic        PixEn;
  logic [10:0] Fila;
  logic [10:0] Columna;
  logic        Pixel;
  logic [11:0] RGB;
  logic        HSync;
  logic        VSync;
  logic        Visible;
  logic        FrameStart;

  modport master (
    input  PixEn, Pixel,
    output Fila, Columna, RGB, HSync, VSync, Visible, FrameStart
  );

  modport slave (
    output PixEn, Pixel,
    input  Fila, Columna, RGB, HSync, VSync, Visible, FrameStart
  );
endinterface

// File: rtl/vga_scan_timing.sv
// VGA scan-coordinate generator with a LAT-deep output pipeline that keeps colour and sync aligned.
module vga_scan_timing #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned LAT      = 1,
  parameter logic [11:0] FG       = 12'hFFF,
  parameter logic [11:0] BG       = 12'h000
) (
  input logic               Clk,
  input logic               Reset,
  vga_scan_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_W  = 11'(H_VIS);
  localparam logic [10:0] V_VIS_W  = 11'(V_VIS);
  localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vis;
  } stage_t;

  localparam stage_t IDLE = {12'h000, ~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [10:0] fila;
  logic [10:0] columna;
  logic        fresh;
  logic        frameStart;
  logic        lineEnd;
  logic        frameEnd;
  stage_t      stage0;
  stage_t      pipe [LAT];

  assign lineEnd  = (columna == H_LAST);
  assign frameEnd = lineEnd && (fila == V_LAST);

  // fresh marks "no tick since reset" so the first tick after release also reports a frame start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fila       <= '0;
      columna    <= '0;
      fresh      <= 1'b1;
      frameStart <= 1'b0;
    end else begin
      frameStart <= vga.PixEn && (fresh || frameEnd);
      if (vga.PixEn) begin
        fresh <= 1'b0;
        if (lineEnd) begin
          columna <= '0;
          fila    <= frameEnd ? '0 : fila + 11'd1;
        end else begin
          columna <= columna + 11'd1;
        end
      end
    end
  end

  always_comb begin
    stage0     = IDLE;
    stage0.vis = (columna < H_VIS_W) && (fila < V_VIS_W);
    stage0.hs  = ((columna >= HS_START) && (columna < HS_END)) ? SYNC_POL : ~SYNC_POL;
    stage0.vs  = ((fila >= VS_START) && (fila < VS_END)) ? SYNC_POL : ~SYNC_POL;
    // Pixel is only looked at inside the active area, so an undriven reader cannot leak into RGB.
    if (stage0.vis) begin
      stage0.rgb = vga.Pixel ? FG : BG;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        pipe[i] <= IDLE;
      end
    end else if (vga.PixEn) begin
      pipe[0] <= stage0;
      for (int unsigned i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign vga.Fila       = fila;
  assign vga.Columna    = columna;
  assign vga.FrameStart = frameStart;
  assign vga.RGB        = pipe[LAT-1].rgb;
  assign vga.HSync      = pipe[LAT-1].hs;
  assign vga.VSync      = pipe[LAT-1].vs;
  assign vga.Visible    = pipe[LAT-1].vis;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: full horizontal timing, shortened frame height, LAT = 2.
module tb_vga_scan_timing;

  localparam int unsigned HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int unsigned VV = 20, VF = 2, VS = 2, VB = 3;
  localparam int unsigned LATV  = 2;
  localparam int unsigned HT    = HV + HF + HS + HB;
  localparam int unsigned VT    = VV + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam logic        POL   = 1'b0;
  localparam logic [11:0] FGV   = 12'hA5C;
  localparam logic [11:0] BGV   = 12'h31F;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  vga_scan_timing_if bus ();

  vga_scan_timing #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL), .LAT(LATV), .FG(FGV), .BG(BGV)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .vga(bus)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned n     = 0;
  bit          tick  = 1'b0;
  bit          measure = 1'b0;
  int unsigned seed;
  int unsigned hsLow = 0, vsLow = 0, visCnt = 0, fsCnt = 0;

  // Reader image: a seeded pseudo-random bit per visible coordinate.
  function automatic logic pat(int unsigned r, int unsigned c);
    int unsigned h;
    h = r * 37 + c * 11 + (c / 7) * 5 + seed;
    return h[2];
  endfunction

  function automatic logic pixFor(logic [10:0] f, logic [10:0] c);
    if ((int'(c) < int'(HV)) && (int'(f) < int'(VV))) return pat(int'(f), int'(c));
    return 1'bx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (tick count %0d)", tag, got, exp, n);
    end
  endtask

  task automatic checkAll();
    int unsigned p, q, r, c;
    logic        eVis, eHs, eVs, eFs;
    logic [11:0] eRgb;
    p   = n % FRAME;
    eFs = tick && ((n == 1) || (p == 0));
    if (n < LATV) begin
      eVis = 1'b0; eHs = ~POL; eVs = ~POL; eRgb = 12'h000;
    end else begin
      q    = (n - LATV) % FRAME;
      r    = q / HT;
      c    = q % HT;
      eVis = (c < HV) && (r < VV);
      eHs  = (c >= HV + HF && c < HV + HF + HS) ? POL : ~POL;
      eVs  = (r >= VV + VF && r < VV + VF + VS) ? POL : ~POL;
      eRgb = eVis ? (pat(r, c) ? FGV : BGV) : 12'h000;
    end
    chk("Fila",       32'(bus.Fila),       32'(p / HT));
    chk("Columna",    32'(bus.Columna),    32'(p % HT));
    chk("FrameStart", 32'(bus.FrameStart), 32'(eFs));
    chk("Visible",    32'(bus.Visible),    32'(eVis));
    chk("HSync",      32'(bus.HSync),      32'(eHs));
    chk("VSync",      32'(bus.VSync),      32'(eVs));
    chk("RGB",        32'(bus.RGB),        32'(eRgb));
    if (measure) begin
      fsCnt += (bus.FrameStart === 1'b1) ? 1 : 0;
      if (tick && n >= LATV && (n - LATV) < FRAME) begin
        hsLow  += (bus.HSync === POL) ? 1 : 0;
        vsLow  += (bus.VSync === POL) ? 1 : 0;
        visCnt += (bus.Visible === 1'b1) ? 1 : 0;
      end
    end
  endtask

  task automatic step(input logic en, input logic rst);
    @(negedge Clk);
    bus.PixEn = en;
    Reset     = rst;
    bus.Pixel = pixFor(bus.Fila, bus.Columna);
    @(posedge Clk);
    #1;
    if (rst) begin
      n = 0; tick = 1'b0;
    end else if (en) begin
      n++; tick = 1'b1;
    end else begin
      tick = 1'b0;
    end
    checkAll();
  endtask

  initial begin
    bit found;
    seed      = $urandom;
    bus.PixEn = 1'b1;
    bus.Pixel = 1'b0;

    // Reset held three clocks with PixEn high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // One full frame plus pipeline drain at full rate, gathering timing statistics.
    measure = 1'b1;
    for (int i = 0; i < int'(FRAME + LATV + 5); i++) step(1'b1, 1'b0);
    measure = 1'b0;
    chk("hsLowTicks",   hsLow,  VT * HS);
    chk("vsLowTicks",   vsLow,  VS * HT);
    chk("visibleTicks", visCnt, VV * HV);
    chk("frameStarts",  fsCnt,  2);

    // Random PixEn gating.
    for (int i = 0; i < 8000; i++) step(logic'($urandom_range(0, 3) != 0), 1'b0);

    // Half-rate strobe for two lines.
    for (int i = 0; i < int'(4 * HT); i++) step(logic'(i % 2), 1'b0);

    // Reset mid-line once Columna reaches 300, with a random PixEn during reset.
    found = 1'b0;
    for (int i = 0; i < int'(2 * HT) && !found; i++) begin
      if (bus.Columna == 11'd300) found = 1'b1;
      else step(1'b1, 1'b0);
    end
    chk("midResetReached", 32'(found), 32'd1);
    step(logic'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 300; i++) step(logic'($urandom_range(0, 1)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
